// File: rtl/mul4_eval_pkg.sv
// Shared types and constants for the mul4 candidate evaluation sequencer.
//   lane_t        : one 16-bit operand/result lane
//   eval_state_e  : sequencer FSM states
//   LFSR_TAPS     : feedback mask for the 64-bit Fibonacci LFSR (taps 64,63,61,60)
//   count_hits    : number of set bits in a 4-lane match vector
package mul4_eval_pkg;

    localparam int unsigned LANE_W = 16;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        COMPARE,
        DONE
    } eval_state_e;

    // Bit positions 63, 62, 60, 59 (taps 64, 63, 61, 60 in 1-based numbering).
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [2:0] count_hits(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

endpackage

// File: rtl/mul4_vec_lfsr.sv
// 64-bit Fibonacci LFSR producing one packed operand vector per step.
//   clk, rst_n : clock, async active-low reset (state clears to 0)
//   load_i     : load seed_i (DEFAULT_SEED substituted when seed_i is 0)
//   seed_i     : 64-bit seed
//   step_i     : advance one step (shift left, feedback into bit 0)
//   state_o    : current LFSR state
// load_i has priority over step_i.
module mul4_vec_lfsr
    import mul4_eval_pkg::*;
#(
    parameter logic [63:0] DEFAULT_SEED = 64'hACE1_1234_5A5A_0F0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [63:0] seed_i,
    input  logic        step_i,
    output logic [63:0] state_o
);

    logic [63:0] state_q;
    logic [63:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            // An all-zero state would lock the LFSR, so zero selects the default.
            state_d = (seed_i == '0) ? DEFAULT_SEED : seed_i;
        end else if (step_i) begin
            state_d = {state_q[62:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mul4_eval_sequencer.sv
// Sequencer and scorer for one mul4 candidate (combinational 4-lane multiplier).
// Drives LFSR-generated operands for NUM_VECTORS vectors, waits SETTLE_CYCLES
// per vector, then scores y3..y0 against the registered golden product.
//   clk, rst_n        : clock, async active-low reset
//   start_i, seed_i   : start pulse and LFSR seed (accepted in IDLE/DONE only)
//   busy_o, done_o    : run in progress / one-cycle completion pulse
//   a1_o..b0_o        : operand lanes to the candidate
//   y3_i..y0_i        : candidate result lanes
//   word_hits_o       : matching 16-bit result words
//   vec_hits_o        : vectors with all four words matching
module mul4_eval_sequencer
    import mul4_eval_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 256,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [63:0] DEFAULT_SEED  = 64'hACE1_1234_5A5A_0F0F,
    parameter int unsigned HIT_W         = $clog2(4 * NUM_VECTORS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [63:0]       seed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LANE_W-1:0] a1_o,
    output logic [LANE_W-1:0] a0_o,
    output logic [LANE_W-1:0] b1_o,
    output logic [LANE_W-1:0] b0_o,
    input  logic [LANE_W-1:0] y3_i,
    input  logic [LANE_W-1:0] y2_i,
    input  logic [LANE_W-1:0] y1_i,
    input  logic [LANE_W-1:0] y0_i,
    output logic [HIT_W-1:0]  word_hits_o,
    output logic [HIT_W-1:0]  vec_hits_o
);

    localparam int unsigned IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int unsigned SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VECTORS - 1);
    localparam logic [SC_W-1:0]  SETTLE_LAST =
        SC_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    eval_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SC_W-1:0]  settle_q, settle_d;
    logic [63:0]      ops_q, ops_d;
    logic [63:0]      golden_q, golden_d;
    logic [HIT_W-1:0] word_hits_q, word_hits_d;
    logic [HIT_W-1:0] vec_hits_q, vec_hits_d;

    logic             lfsr_load;
    logic             lfsr_step;
    logic [63:0]      lfsr_state;
    logic [3:0]       lane_match;

    mul4_vec_lfsr #(
        .DEFAULT_SEED(DEFAULT_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (lfsr_load),
        .seed_i (seed_i),
        .step_i (lfsr_step),
        .state_o(lfsr_state)
    );

    assign lane_match[3] = (y3_i == lane_t'(golden_q[63:48]));
    assign lane_match[2] = (y2_i == lane_t'(golden_q[47:32]));
    assign lane_match[1] = (y1_i == lane_t'(golden_q[31:16]));
    assign lane_match[0] = (y0_i == lane_t'(golden_q[15:0]));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        ops_d       = ops_q;
        golden_d    = golden_q;
        word_hits_d = word_hits_q;
        vec_hits_d  = vec_hits_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    lfsr_load   = 1'b1;
                    idx_d       = '0;
                    word_hits_d = '0;
                    vec_hits_d  = '0;
                    state_d     = APPLY;
                end else begin
                    state_d = IDLE;
                end
            end
            APPLY: begin
                // Operands and golden product both come from the same LFSR state,
                // so they stay aligned through SETTLE and COMPARE.
                ops_d    = lfsr_state;
                golden_d = 64'(lfsr_state[63:32]) * 64'(lfsr_state[31:0]);
                settle_d = '0;
                state_d  = (SETTLE_CYCLES == 0) ? COMPARE : SETTLE;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = COMPARE;
                end else begin
                    settle_d = settle_q + SC_W'(1);
                end
            end
            COMPARE: begin
                word_hits_d = word_hits_q + HIT_W'(count_hits(lane_match));
                if (&lane_match) begin
                    vec_hits_d = vec_hits_q + HIT_W'(1);
                end
                lfsr_step = 1'b1;
                idx_d     = idx_q + IDX_W'(1);
                state_d   = (idx_q == IDX_LAST) ? DONE : APPLY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            settle_q    <= '0;
            ops_q       <= '0;
            golden_q    <= '0;
            word_hits_q <= '0;
            vec_hits_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            ops_q       <= ops_d;
            golden_q    <= golden_d;
            word_hits_q <= word_hits_d;
            vec_hits_q  <= vec_hits_d;
        end
    end

    assign busy_o      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == COMPARE);
    assign done_o      = (state_q == DONE);
    assign a1_o        = lane_t'(ops_q[63:48]);
    assign a0_o        = lane_t'(ops_q[47:32]);
    assign b1_o        = lane_t'(ops_q[31:16]);
    assign b0_o        = lane_t'(ops_q[15:0]);
    assign word_hits_o = word_hits_q;
    assign vec_hits_o  = vec_hits_q;

endmodule
